// File: rtl/sram_bank_ctrl_pkg.sv
// Shared types and helpers for the multi-bank asynchronous SRAM controller.
package sram_bank_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    WREC = 2'd3
  } state_t;

  localparam int MAX_WAIT = 15;
  localparam int WAIT_W   = $clog2(MAX_WAIT + 1);

  // The bank field is always at least one bit wide, even for a single bank.
  function automatic int bsel_w(input int n_banks);
    return (n_banks <= 2) ? 1 : $clog2(n_banks);
  endfunction

endpackage

// File: rtl/sram_bank_ctrl_if.sv
// CPU-side request/response port of the SRAM bank controller.
interface sram_bank_ctrl_if #(
  parameter int ADDR_W = 20,
  parameter int BSEL_W = 1,
  parameter int DATA_W = 32
);
  // A request transfers on a rising edge where req_valid and req_ready are both 1; the master holds
  // all req_* fields stable while req_valid is high. resp_valid is a one-cycle pulse with no back-pressure.
  logic                     req_valid;
  logic                     req_ready;
  logic                     req_we;
  logic [ADDR_W+BSEL_W-1:0] req_addr;
  logic [DATA_W/8-1:0]      req_be;
  logic [DATA_W-1:0]        req_wdata;
  logic                     resp_valid;
  logic [DATA_W-1:0]        resp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_be, req_wdata,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_be, req_wdata,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/sram_wait_timer.sv
// Loadable down-counter that times the OE/WE low phase; done is high on the final counted cycle.
module sram_wait_timer
  import sram_bank_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WAIT_W-1:0] load_val,
  input  logic              en,
  output logic              done
);
  logic [WAIT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = en && (cnt == '0);
endmodule

// File: rtl/sram_bank_ctrl.sv
// Serialising controller for N asynchronous SRAM banks with programmable read/write wait states.
// Define SRAM_BANK_CTRL_POSTED_WR_EN to acknowledge writes the cycle after accept (posted writes).
module sram_bank_ctrl
  import sram_bank_ctrl_pkg::*;
#(
  parameter int N_BANKS = 2,
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 32,
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  sram_bank_ctrl_if.slave               bus,
  output logic [N_BANKS*ADDR_W-1:0]     ram_addr,
  output logic [DATA_W-1:0]             ram_wdata,
  output logic [N_BANKS-1:0]            ram_data_oe,
  input  logic [N_BANKS*DATA_W-1:0]     ram_rdata,
  output logic [N_BANKS-1:0]            ram_ce_n,
  output logic [N_BANKS-1:0]            ram_oe_n,
  output logic [N_BANKS-1:0]            ram_we_n,
  output logic [N_BANKS*DATA_W/8-1:0]   ram_be_n,
  output state_t                        dbg_state
);
  localparam int BSEL_W = bsel_w(N_BANKS);
  localparam int BE_W   = DATA_W / 8;
  localparam logic [WAIT_W-1:0] RD_LOAD = WAIT_W'(RD_WAIT - 1);
  localparam logic [WAIT_W-1:0] WR_LOAD = WAIT_W'(WR_WAIT - 1);

  state_t              state, state_next;
  logic [ADDR_W-1:0]   addr_q;
  logic [BSEL_W-1:0]   bank_q;
  logic [BE_W-1:0]     be_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                resp_valid_q, resp_next;
  logic [DATA_W-1:0]   rdata_q, sel_rdata;
  logic [BSEL_W-1:0]   bank_in;
  logic                in_range, accept;
  logic                timer_load, timer_en, timer_done;
  logic [WAIT_W-1:0]   timer_val;

  assign bank_in       = bus.req_addr[ADDR_W +: BSEL_W];
  assign in_range      = int'(bank_in) < N_BANKS;
  assign bus.req_ready = (state == IDLE) && !rst;
  assign accept        = bus.req_valid && bus.req_ready;
  assign timer_en      = (state == RD) || (state == WR);

  sram_wait_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_val),
    .en       (timer_en),
    .done     (timer_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Out-of-range banks never leave IDLE; they are answered directly from the accept cycle.
  always_comb begin
    state_next = state;
    timer_load = 1'b0;
    timer_val  = '0;
    case (state)
      IDLE: begin
        if (accept && in_range) begin
          timer_load = 1'b1;
          if (bus.req_we) begin
            state_next = WR;
            timer_val  = WR_LOAD;
          end else begin
            state_next = RD;
            timer_val  = RD_LOAD;
          end
        end
      end
      RD:      if (timer_done) state_next = IDLE;
      WR:      if (timer_done) state_next = WREC;
      WREC:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
`ifdef SRAM_BANK_CTRL_POSTED_WR_EN
    resp_next = ((state == RD) && timer_done) || (accept && (!in_range || bus.req_we));
`else
    resp_next = ((state == RD) && timer_done) || ((state == WR) && timer_done) ||
                (accept && !in_range);
`endif
  end

  always_comb begin
    sel_rdata = '0;
    for (int b = 0; b < N_BANKS; b++) begin
      if (int'(bank_q) == b) sel_rdata = ram_rdata[b*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      addr_q       <= '0;
      bank_q       <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
    end else begin
      resp_valid_q <= resp_next;
      if ((state == RD) && timer_done) begin
        rdata_q <= sel_rdata;
      end else if (accept && !in_range && !bus.req_we) begin
        rdata_q <= '0;
      end
      if (accept) begin
        addr_q  <= bus.req_addr[ADDR_W-1:0];
        bank_q  <= bank_in;
        be_q    <= bus.req_be;
        wdata_q <= bus.req_wdata;
      end
    end
  end

  // WREC keeps CE and the data drive up for hold time but releases WE and the byte lanes.
  always_comb begin
    ram_ce_n    = '1;
    ram_oe_n    = '1;
    ram_we_n    = '1;
    ram_data_oe = '0;
    ram_be_n    = '1;
    for (int b = 0; b < N_BANKS; b++) begin
      if ((int'(bank_q) == b) && (state != IDLE)) begin
        ram_ce_n[b]    = 1'b0;
        ram_oe_n[b]    = (state != RD);
        ram_we_n[b]    = (state != WR);
        ram_data_oe[b] = (state == WR) || (state == WREC);
        if (state == RD) begin
          ram_be_n[b*BE_W +: BE_W] = '0;
        end else if (state == WR) begin
          ram_be_n[b*BE_W +: BE_W] = ~be_q;
        end
      end
    end
  end

  assign ram_addr        = {N_BANKS{addr_q}};
  assign ram_wdata       = wdata_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_rdata  = rdata_q;
  assign dbg_state       = state;
endmodule

// File: tb/tb_sram_bank_ctrl.sv
// Self-checking bench for sram_bank_ctrl: three banks (bank index 3 unmapped), behavioural SRAM chips.
module tb_sram_bank_ctrl;
  import sram_bank_ctrl_pkg::*;

  localparam int N_BANKS = 3;
  localparam int ADDR_W  = 20;
  localparam int DATA_W  = 32;
  localparam int RD_WAIT = 2;
  localparam int WR_WAIT = 2;
  localparam int BSEL_W  = 2;
  localparam int RL      = RD_WAIT + 1;
  localparam int BL      = 1;
`ifdef SRAM_BANK_CTRL_POSTED_WR_EN
  localparam int WL      = 1;
`else
  localparam int WL      = WR_WAIT + 1;
`endif

  logic                        clk;
  logic                        rst;
  logic [N_BANKS*ADDR_W-1:0]   ram_addr;
  logic [DATA_W-1:0]           ram_wdata;
  logic [N_BANKS-1:0]          ram_data_oe;
  logic [N_BANKS*DATA_W-1:0]   ram_rdata;
  logic [N_BANKS-1:0]          ram_ce_n, ram_oe_n, ram_we_n;
  logic [N_BANKS*DATA_W/8-1:0] ram_be_n;
  state_t                      dbg_state;

  sram_bank_ctrl_if #(.ADDR_W(ADDR_W), .BSEL_W(BSEL_W), .DATA_W(DATA_W)) bus ();

  sram_bank_ctrl #(
    .N_BANKS(N_BANKS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_data_oe (ram_data_oe),
    .ram_rdata   (ram_rdata),
    .ram_ce_n    (ram_ce_n),
    .ram_oe_n    (ram_oe_n),
    .ram_we_n    (ram_we_n),
    .ram_be_n    (ram_be_n),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DATA_W:0] exp_q[$];
  logic [31:0] chip_mem [int];
  logic [31:0] ref_mem  [int];
  int oe_cnt [N_BANKS];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int key(input int b, input logic [19:0] a);
    return b * (1 << 20) + int'(a);
  endfunction

  function automatic logic [31:0] init_word(input int k);
    return {4'h5, 4'(k >> 20), 4'h0, 20'(k)};
  endfunction

  function automatic logic [31:0] chip_read(input int k);
    return chip_mem.exists(k) ? chip_mem[k] : init_word(k);
  endfunction

  // Reference model: returns {check_data, expected rdata} and applies writes.
  function automatic logic [32:0] model_req(input logic we, input int bank, input logic [19:0] a,
                                            input logic [3:0] be, input logic [31:0] wd);
    int k;
    logic [31:0] w;
    if (bank >= N_BANKS) return we ? 33'h0 : {1'b1, 32'h0};
    k = key(bank, a);
    w = ref_mem.exists(k) ? ref_mem[k] : init_word(k);
    if (!we) return {1'b1, w};
    for (int i = 0; i < 4; i++) if (be[i]) w[i*8 +: 8] = wd[i*8 +: 8];
    ref_mem[k] = w;
    return 33'h0;
  endfunction

  // ---------------- SRAM chips + strobe rules ----------------
  initial begin
    ram_rdata = '0;
    for (int b = 0; b < N_BANKS; b++) oe_cnt[b] = 0;
    forever begin
      @(negedge clk);
      for (int b = 0; b < N_BANKS; b++) begin
        int k;
        logic [31:0] w;
        k = key(b, ram_addr[b*ADDR_W +: ADDR_W]);
        if (!ram_ce_n[b] && !ram_we_n[b]) begin
          w = chip_read(k);
          for (int i = 0; i < 4; i++)
            if (!ram_be_n[b*4 + i]) w[i*8 +: 8] = ram_wdata[i*8 +: 8];
          chip_mem[k] = w;
          check("we_without_data_oe", 64'(ram_data_oe[b]), 64'd1);
        end
        if (!ram_ce_n[b] && !ram_oe_n[b]) oe_cnt[b]++;
        else oe_cnt[b] = 0;
        ram_rdata[b*DATA_W +: DATA_W] = (oe_cnt[b] >= RD_WAIT) ? chip_read(k) : (32'hDEAD_0000 | 32'(b));
        check("oe_we_overlap", 64'(!ram_oe_n[b] && !ram_we_n[b]), 64'd0);
        check("data_oe_with_oe", 64'(ram_data_oe[b] && !ram_oe_n[b]), 64'd0);
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [DATA_W:0] e;
    forever begin
      @(negedge clk);
      if (bus.resp_valid) begin
        if (exp_q.size() == 0) begin
          check("resp_unexpected", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          if (e[DATA_W]) check("resp_rdata", 64'(bus.resp_rdata), 64'(e[DATA_W-1:0]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic we, input int bank, input logic [19:0] a, input logic [3:0] be,
                       input logic [31:0] wd, input logic [32:0] e, output int waits);
    logic r;
    exp_q.push_back(e);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = {2'(bank), a};
    bus.req_be    = be;
    bus.req_wdata = wd;
    waits = 0;
    do begin
      r = bus.req_ready;
      @(posedge clk);
      #1;
      waits++;
    end while (!r && waits < 50);
    check("accept", 64'(r), 64'd1);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_resp(input int exp_lat, input string name);
    int lat;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.resp_valid && lat < 20);
    check(name, 64'(lat), 64'(exp_lat));
  endtask

  typedef struct {
    logic        we;
    int          bank;
    logic [19:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    int w;
    logic [32:0] e;

    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_be    = '0;
    bus.req_wdata = '0;
    chip_mem[key(0, 20'h00010)] = 32'h1234_5678;
    ref_mem[key(0, 20'h00010)]  = 32'h1234_5678;

    vecs[0]  = '{1'b0, 0, 20'h00010, 4'hF, 32'h0,          32'h1234_5678, RL};
    vecs[1]  = '{1'b1, 1, 20'hFFFFF, 4'b0101, 32'hAABB_CCDD, 32'h0,       WL};
    vecs[2]  = '{1'b0, 1, 20'hFFFFF, 4'hF, 32'h0,          32'h51BB_FFDD, RL};
    vecs[3]  = '{1'b1, 0, 20'h00010, 4'hF, 32'hCAFE_F00D,  32'h0,         WL};
    vecs[4]  = '{1'b0, 0, 20'h00010, 4'hF, 32'h0,          32'hCAFE_F00D, RL};
    vecs[5]  = '{1'b1, 0, 20'h00020, 4'h0, 32'h1111_1111,  32'h0,         WL};
    vecs[6]  = '{1'b0, 0, 20'h00020, 4'hF, 32'h0,          32'h5000_0020, RL};
    vecs[7]  = '{1'b1, 2, 20'h12345, 4'b1100, 32'h5566_7788, 32'h0,       WL};
    vecs[8]  = '{1'b0, 2, 20'h12345, 4'hF, 32'h0,          32'h5566_2345, RL};
    vecs[9]  = '{1'b0, 3, 20'h00001, 4'hF, 32'h0,          32'h0,         BL};
    vecs[10] = '{1'b1, 3, 20'h00002, 4'hF, 32'h9999_9999,  32'h0,         BL};
    vecs[11] = '{1'b0, 1, 20'h00000, 4'hF, 32'h0,          32'h5100_0000, RL};

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_resp_rdata", 64'(bus.resp_rdata), 64'd0);
    check("rst_ce_n", 64'(ram_ce_n), 64'h7);
    check("rst_oe_n", 64'(ram_oe_n), 64'h7);
    check("rst_we_n", 64'(ram_we_n), 64'h7);
    check("rst_be_n", 64'(ram_be_n), 64'hFFF);
    check("rst_data_oe", 64'(ram_data_oe), 64'h0);
    check("rst_ram_addr", 64'(ram_addr), 64'h0);
    check("rst_ram_wdata", 64'(ram_wdata), 64'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", 64'(bus.req_ready), 64'd1);

    // Table-driven vectors
    for (int i = 0; i < 12; i++) begin
      e = model_req(vecs[i].we, vecs[i].bank, vecs[i].addr, vecs[i].be, vecs[i].wdata);
      e = vecs[i].we ? 33'h0 : {1'b1, vecs[i].rdata};
      issue(vecs[i].we, vecs[i].bank, vecs[i].addr, vecs[i].be, vecs[i].wdata, e, w);
      wait_resp(vecs[i].lat, $sformatf("vec%0d_latency", i));
    end

    // Write strobe timing on bank 1, then back-to-back readback
    e = model_req(1'b1, 1, 20'h00ABC, 4'b0101, 32'hAABB_CCDD);
    issue(1'b1, 1, 20'h00ABC, 4'b0101, 32'hAABB_CCDD, e, w);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check($sformatf("wr_c%0d_resp_valid", c), 64'(bus.resp_valid), 64'(c == WL));
      check($sformatf("wr_c%0d_req_ready", c), 64'(bus.req_ready), 64'd0);
      check($sformatf("wr_c%0d_ce_n", c), 64'(ram_ce_n), 64'h5);
      check($sformatf("wr_c%0d_oe_n", c), 64'(ram_oe_n), 64'h7);
      check($sformatf("wr_c%0d_data_oe", c), 64'(ram_data_oe), 64'h2);
      check($sformatf("wr_c%0d_we_n", c), 64'(ram_we_n), (c < 3) ? 64'h5 : 64'h7);
      check($sformatf("wr_c%0d_be_n", c), 64'(ram_be_n[7:4]), (c < 3) ? 64'hA : 64'hF);
    end
    e = model_req(1'b0, 1, 20'h00ABC, 4'hF, 32'h0);
    check("wr_rd_model", 64'(e[31:0]), 64'h51BB_0ADD);
    issue(1'b0, 1, 20'h00ABC, 4'hF, 32'h0, e, w);
    check("wr_then_rd_accept_wait", 64'(w), 64'd2);
    wait_resp(RL, "wr_then_rd_latency");

    // Read immediately after a read response: no bubble
    e = model_req(1'b0, 0, 20'h00010, 4'hF, 32'h0);
    issue(1'b0, 0, 20'h00010, 4'hF, 32'h0, e, w);
    check("rd_rd_accept_wait", 64'(w), 64'd1);
    wait_resp(RL, "rd_rd_latency");

    // Unmapped bank: no strobes, response next cycle with zero data
    e = model_req(1'b0, 3, 20'h00005, 4'hF, 32'h0);
    issue(1'b0, 3, 20'h00005, 4'hF, 32'h0, e, w);
    @(negedge clk);
    check("bad_bank_resp_valid", 64'(bus.resp_valid), 64'd1);
    check("bad_bank_ce_n", 64'(ram_ce_n), 64'h7);
    check("bad_bank_oe_n", 64'(ram_oe_n), 64'h7);
    check("bad_bank_ready", 64'(bus.req_ready), 64'd1);

    // Reset during the first WR cycle
    e = model_req(1'b1, 0, 20'h00300, 4'hF, 32'h0BAD_0BAD);
    issue(1'b1, 0, 20'h00300, 4'hF, 32'h0BAD_0BAD, e, w);
    rst = 1'b1;
    @(negedge clk);
    check("midwr_rst_req_ready", 64'(bus.req_ready), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midwr_ce_n", 64'(ram_ce_n), 64'h7);
    check("midwr_we_n", 64'(ram_we_n), 64'h7);
    check("midwr_be_n", 64'(ram_be_n), 64'hFFF);
    check("midwr_data_oe", 64'(ram_data_oe), 64'h0);
    check("midwr_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("midwr_state", 64'(dbg_state), 64'(IDLE));
    check("midwr_req_ready", 64'(bus.req_ready), 64'd1);
    exp_q.delete();

    // Random traffic over a small address window
    for (int i = 0; i < 24; i++) begin
      logic        rwe;
      int          rbank;
      logic [19:0] ra;
      logic [3:0]  rbe;
      logic [31:0] rwd;
      rwe   = 1'($urandom_range(0, 1));
      rbank = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
      ra    = 20'h00040 + 20'($urandom_range(0, 3));
      rbe   = 4'($urandom_range(0, 15));
      rwd   = $urandom;
      e = model_req(rwe, rbank, ra, rbe, rwd);
      issue(rwe, rbank, ra, rbe, rwd, e, w);
      wait_resp((rbank >= N_BANKS) ? BL : (rwe ? WL : RL), $sformatf("rand%0d_latency", i));
    end

    repeat (6) @(negedge clk);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
